// File: rtl/vigna_coproc_pkg.sv
// Shared encodings for the vigna coprocessor dispatch path: M-extension funct3 values,
// dispatch FSM states and the signed-overflow operand constant.
package vigna_coproc_pkg;

   localparam logic [2:0] FUNC_MUL    = 3'b000;
   localparam logic [2:0] FUNC_MULH   = 3'b001;
   localparam logic [2:0] FUNC_MULHSU = 3'b010;
   localparam logic [2:0] FUNC_MULHU  = 3'b011;
   localparam logic [2:0] FUNC_DIV    = 3'b100;
   localparam logic [2:0] FUNC_DIVU   = 3'b101;
   localparam logic [2:0] FUNC_REM    = 3'b110;
   localparam logic [2:0] FUNC_REMU   = 3'b111;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WB    = 2'd2
   } state_e;

endpackage

// File: rtl/vigna_coproc_fastpath.sv
// Combinational detector for M-extension requests whose result is fixed by the ISA
// (zero multiplicand, divide by zero, signed overflow) and therefore needs no coprocessor.
module vigna_coproc_fastpath
   import vigna_coproc_pkg::*;
(
   input  logic [2:0]  func,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic        hit,
   output logic [31:0] value
);

   logic op2_zero;
   logic overflow;

   assign op2_zero = (op2 == 32'd0);
   assign overflow = (op1 == INT_MIN) && (op2 == 32'hFFFF_FFFF);

   always_comb begin
      hit   = 1'b0;
      value = 32'd0;
      case (func)
         FUNC_MUL, FUNC_MULH, FUNC_MULHSU, FUNC_MULHU: begin
            hit = (op1 == 32'd0) || op2_zero;
         end
         FUNC_DIV: begin
            if (op2_zero) begin
               hit   = 1'b1;
               value = 32'hFFFF_FFFF;
            end else if (overflow) begin
               hit   = 1'b1;
               value = INT_MIN;
            end
         end
         FUNC_DIVU: begin
            hit   = op2_zero;
            value = 32'hFFFF_FFFF;
         end
         FUNC_REM: begin
            // Overflow remainder is zero, which is already the default value.
            hit   = op2_zero || overflow;
            value = op2_zero ? op1 : 32'd0;
         end
         FUNC_REMU: begin
            hit   = op2_zero;
            value = op1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/vigna_coproc_dispatch.sv
// Core-side initiator for the 3-bit-func coprocessor port: one request in flight, result handed to writeback.
// Define VIGNA_COPROC_FASTPATH_EN to resolve ISA-fixed results locally without issuing to the coprocessor.
module vigna_coproc_dispatch
   import vigna_coproc_pkg::*;
#(
   parameter logic [2:0] COPROC_ID = 3'd0,
   parameter int         RD_W      = 5
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_func,
   input  logic [RD_W-1:0] req_rd,
   input  logic [31:0]     req_op1,
   input  logic [31:0]     req_op2,
   output logic            cp_valid,
   input  logic            cp_ready,
   output logic [2:0]      cp_func,
   output logic [2:0]      cp_id,
   output logic [31:0]     cp_op1,
   output logic [31:0]     cp_op2,
   input  logic [31:0]     cp_result,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   output logic            busy
);

   state_e      state_q, state_d;
   logic        load_req;
   logic        load_result;
   logic [31:0] result_d;

`ifdef VIGNA_COPROC_FASTPATH_EN
   logic        fp_hit;
   logic [31:0] fp_value;

   vigna_coproc_fastpath u_fastpath (
      .func  (req_func),
      .op1   (req_op1),
      .op2   (req_op2),
      .hit   (fp_hit),
      .value (fp_value)
   );
`endif

   assign cp_id = COPROC_ID;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cp_func <= '0;
         cp_op1  <= '0;
         cp_op2  <= '0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else begin
         state_q <= state_d;
         if (load_req) begin
            cp_func <= req_func;
            cp_op1  <= req_op1;
            cp_op2  <= req_op2;
            wb_rd   <= req_rd;
         end
         if (load_result) begin
            wb_data <= result_d;
         end
      end
   end

   // Writes to x0 are accepted and dropped; cp_valid is a pure state decode, so it falls the cycle after cp_ready.
   always_comb begin
      state_d     = state_q;
      load_req    = 1'b0;
      load_result = 1'b0;
      result_d    = cp_result;
      req_ready   = 1'b0;
      cp_valid    = 1'b0;
      wb_valid    = 1'b0;
      busy        = 1'b1;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid && (req_rd != '0)) begin
               load_req = 1'b1;
`ifdef VIGNA_COPROC_FASTPATH_EN
               if (fp_hit) begin
                  load_result = 1'b1;
                  result_d    = fp_value;
                  state_d     = S_WB;
               end else begin
                  state_d = S_ISSUE;
               end
`else
               state_d = S_ISSUE;
`endif
            end
         end
         S_ISSUE: begin
            cp_valid = 1'b1;
            if (cp_ready) begin
               load_result = 1'b1;
               state_d     = S_WB;
            end
         end
         S_WB: begin
            wb_valid = 1'b1;
            if (wb_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_vigna_coproc_dispatch.sv
// Randomized self-checking bench for vigna_coproc_dispatch against an ISA-level M-extension model.
// Honors VIGNA_COPROC_FASTPATH_EN the same way as the design.
module tb_vigna_coproc_dispatch;

   localparam int RD_W = 5;

   logic            clk = 1'b0;
   logic            resetn;
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_func;
   logic [RD_W-1:0] req_rd;
   logic [31:0]     req_op1;
   logic [31:0]     req_op2;
   logic            cp_valid;
   logic            cp_ready;
   logic [2:0]      cp_func;
   logic [2:0]      cp_id;
   logic [31:0]     cp_op1;
   logic [31:0]     cp_op2;
   logic [31:0]     cp_result;
   logic            wb_valid;
   logic            wb_ready;
   logic [RD_W-1:0] wb_rd;
   logic [31:0]     wb_data;
   logic            busy;

   int n_checks = 0;
   int n_errors = 0;

   vigna_coproc_dispatch #(.COPROC_ID(3'd0), .RD_W(RD_W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_func  (req_func),
      .req_rd    (req_rd),
      .req_op1   (req_op1),
      .req_op2   (req_op2),
      .cp_valid  (cp_valid),
      .cp_ready  (cp_ready),
      .cp_func   (cp_func),
      .cp_id     (cp_id),
      .cp_op1    (cp_op1),
      .cp_op2    (cp_op2),
      .cp_result (cp_result),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension result, computed with 64-bit host arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, ub, p;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit fast_expected(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef VIGNA_COPROC_FASTPATH_EN
      if (f < 3'd4) return (a == 0) || (b == 0);
      if (b == 0) return 1'b1;
      return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom % 6)
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Writeback phase, entered at the first negedge where wb_valid should be high.
   task automatic do_wb(input string tag, input int dly, input logic [31:0] exp_data);
      bit hold = 1'b1;
      for (int k = 0; k < dly; k++) begin
         wb_ready  = 1'b0;
         cp_ready  = 1'($urandom);
         cp_result = $urandom;
         @(negedge clk);
         hold &= (wb_valid === 1'b1) && (wb_data === exp_data) && (req_ready === 1'b0);
      end
      if (dly > 0) check({tag, "_wb_hold"}, hold, 1);
      cp_ready = 1'b0;
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      check({tag, "_retire"}, {wb_valid, req_ready, busy}, 3'b010);
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [RD_W-1:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input int cp_dly, input int wb_dly);
      logic [31:0] exp;
      int          t = 0;
      bit          stable = 1'b1;
      exp = ref_result(f, a, b);
      while (req_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_idle"}, {req_ready, cp_valid}, 2'b10);
      req_valid = 1'b1;
      req_func  = f;
      req_rd    = rd;
      req_op1   = a;
      req_op2   = b;
      @(negedge clk);
      req_valid = 1'b0;
      req_func  = 3'($urandom);
      req_op1   = $urandom;
      req_op2   = $urandom;
      req_rd    = 5'($urandom);
      if (rd == 0) begin
         check({tag, "_x0"}, {cp_valid, wb_valid, req_ready}, 3'b001);
      end else if (fast_expected(f, a, b)) begin
         check({tag, "_fast"}, {cp_valid, wb_valid, req_ready}, 3'b010);
         check({tag, "_fast_data"}, {wb_rd, wb_data}, {rd, exp});
         do_wb(tag, wb_dly, exp);
      end else begin
         for (int k = 0; k <= cp_dly; k++) begin
            stable &= (cp_valid === 1'b1) && (cp_func === f) && (cp_op1 === a) &&
                      (cp_op2 === b) && (cp_id === 3'd0) && (wb_valid === 1'b0);
            if (k < cp_dly) @(negedge clk);
         end
         check({tag, "_issue"}, stable, 1);
         cp_ready  = 1'b1;
         cp_result = exp;
         if (wb_dly == 0) wb_ready = 1'b1;
         @(negedge clk);
         cp_ready  = 1'b0;
         cp_result = $urandom;
         check({tag, "_done"}, {cp_valid, wb_valid, req_ready}, 3'b010);
         check({tag, "_data"}, {wb_rd, wb_data}, {rd, exp});
         do_wb(tag, wb_dly, exp);
      end
   endtask

   initial begin
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_func  = 3'd0;
      req_rd    = '0;
      req_op1   = 32'd0;
      req_op2   = 32'd0;
      cp_ready  = 1'b0;
      cp_result = 32'd0;
      wb_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {req_ready, cp_valid, wb_valid, busy}, 4'b1000);
      check("reset_data", {cp_func, cp_id, cp_op1, cp_op2, wb_rd, wb_data}, '0);
      resetn = 1'b1;
      @(negedge clk);

      run_op("mul_long", 3'd0, 5'd5, 32'd7, 32'd6, 34, 1);
      run_op("divu_wbstall", 3'd5, 5'd3, 32'd100, 32'd7, 2, 3);
      run_op("x0_mulhu", 3'd3, 5'd0, 32'hFFFF_FFFF, 32'd2, 0, 0);
      run_op("b2b_rem", 3'd6, 5'd9, 32'hFFFF_FFF9, 32'd2, 1, 0);
      run_op("b2b_mul", 3'd0, 5'd10, 32'd3, 32'd3, 0, 0);
      run_op("div_by0", 3'd4, 5'd12, 32'd55, 32'd0, 3, 0);
      run_op("div_ovf", 3'd4, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1);

      // Reset in the middle of an issue, then a stale cp_ready that must be ignored.
      req_valid = 1'b1;
      req_func  = 3'd0;
      req_rd    = 5'd7;
      req_op1   = 32'd11;
      req_op2   = 32'd13;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pre_issue", cp_valid, 1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("rst_mid", {cp_valid, wb_valid, req_ready, busy}, 4'b0010);
      cp_ready  = 1'b1;
      cp_result = 32'hDEAD_BEEF;
      @(negedge clk);
      cp_ready = 1'b0;
      @(negedge clk);
      check("rst_late_ready", {cp_valid, wb_valid, req_ready, wb_data}, {3'b001, 32'd0});

      for (int i = 0; i < 40; i++) begin
         logic [RD_W-1:0] rd;
         rd = ($urandom % 5 == 0) ? '0 : 5'($urandom_range(1, 31));
         run_op($sformatf("rnd%0d", i), 3'($urandom), rd, rand_op(), rand_op(),
                $urandom_range(0, 6), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
